fetch_queue: RTL and testbench

// - Instruction prefetch FIFO between if_stage (producer) and id_stage (consumer).
// - Decouples fetch from decode stalls: fetch keeps pushing while id_stage is stalled, until the queue is full.
// - A branch flush from ex_stage discards every queued instruction.
// - When the queue is empty, id_stage sees a NOP (addi x0,x0,0).

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the canonical NOP encoding and the
// fetch entry layout used by the prefetch queue.
package core;

  localparam int DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between if_stage and id_stage with branch flush.
// Optional zero-latency empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
  import core::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = core::DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [DATA_WIDTH-1:0]        instr_i,
  input  logic [DATA_WIDTH-1:0]        pc_i,
  input  logic                         flush_i,
  input  logic                         pop_ready_i,
  output logic                         pop_valid_o,
  output logic [DATA_WIDTH-1:0]        instr_o,
  output logic [DATA_WIDTH-1:0]        pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            q_empty;
  logic            q_full;
  logic            bypass_take;
  logic            bypass_consume;
  logic            push_fire;
  logic            pop_fire;

  // Handshakes and head selection; full-ness is judged on the registered count
  // only, so a same-cycle pop never frees a slot for a same-cycle push.
  always_comb begin
    q_empty        = (count == '0);
    q_full         = (count == CW'(DEPTH));
    bypass_take    = 1'b0;
    bypass_consume = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass_take    = q_empty & push_valid_i & ~flush_i;
    bypass_consume = bypass_take & pop_ready_i;
`endif
    push_ready_o = ~q_full;
    pop_valid_o  = ~q_empty | bypass_take;
    push_fire    = push_valid_i & ~q_full & ~bypass_consume;
    pop_fire     = ~q_empty & pop_ready_i;
    instr_o      = NOP_INSTR;
    pc_o         = '0;
    if (!q_empty) begin
      instr_o = mem[rd_ptr].instr;
      pc_o    = mem[rd_ptr].pc;
    end else if (bypass_take) begin
      instr_o = instr_i;
      pc_o    = pc_i;
    end
    count_o = count;
  end

  // Reset outranks flush, flush outranks any push/pop; storage is never cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= '{instr: instr_i, pc: pc_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// against a queue-based reference model. Honours FETCHQ_BYPASS_EN if defined.
module tb_fetch_queue;
  import core::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] instr = '0;
  logic [DW-1:0] pc = '0;
  logic          flush = 1'b0;
  logic          pop_ready = 1'b0;
  logic          pop_valid;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] pc_out;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
  } ent_t;
  ent_t q[$];

  fetch_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .instr_i      (instr),
    .pc_i         (pc),
    .flush_i      (flush),
    .pop_ready_i  (pop_ready),
    .pop_valid_o  (pop_valid),
    .instr_o      (instr_out),
    .pc_o         (pc_out),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs from the abstract model and the current inputs.
  function automatic bit byp_now();
    return BYP && q.size() == 0 && push_valid && !flush;
  endfunction

  function automatic logic e_valid();
    return (q.size() > 0) || byp_now();
  endfunction

  function automatic logic [DW-1:0] e_instr();
    if (q.size() > 0) return q[0].instr;
    if (byp_now()) return instr;
    return NOP_INSTR;
  endfunction

  function automatic logic [DW-1:0] e_pc();
    if (q.size() > 0) return q[0].pc;
    if (byp_now()) return pc;
    return '0;
  endfunction

  // Model state update with the inputs present at the clock edge.
  function automatic void model_step();
    int sz;
    bit popf, pushf;
    sz = q.size();
    if (!rst || flush) begin
      q.delete();
    end else if (byp_now() && pop_ready) begin
      // consumed directly from the input; nothing stored
    end else begin
      popf  = pop_ready && sz > 0;
      pushf = push_valid && sz < DEPTH;
      if (popf) void'(q.pop_front());
      if (pushf) q.push_back('{instr: instr, pc: pc});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    instr      = '0;
    pc         = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (pop_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got %b exp 0", pop_valid);
    end
    checks++;
    if (instr_out !== 32'h0000_0013) begin
      errors++; $display("[TB] FAIL reset_instr got %h exp 00000013", instr_out);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc got %h exp 0", pc_out);
    end
    checks++;
    if (push_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready got %b exp 1", push_ready);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00C3_0383;
    prog[2] = 32'h0053_8113;
    prog[3] = 32'h0051_6093;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      pop_ready  = 1'b0;
      instr      = prog[i];
      pc         = 32'(i * 4);
      tick();
      checks++;
      if (count !== CW'(i + 1)) begin
        errors++; $display("[TB] FAIL fill_count got %0d exp %0d", count, i + 1);
      end
    end
    instr = 32'hDEAD_BEEF;
    pc    = 32'h0000_0010;
    #1;
    checks++;
    if (push_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_ready got %b exp 0", push_ready);
    end
    tick();
    push_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("[TB] FAIL full_refuse_count got %0d exp 4", count);
    end
    checks++;
    if (instr_out !== 32'h0050_0093 || pc_out !== 32'h0) begin
      errors++; $display("[TB] FAIL full_head got %h/%h exp 00500093/0", instr_out, pc_out);
    end
  endtask

  task automatic test_drain_wrap();
    logic [DW-1:0] exp_pc [4];
    exp_pc[0] = 32'h8;
    exp_pc[1] = 32'hC;
    exp_pc[2] = 32'h10;
    exp_pc[3] = 32'h14;
    idle_inputs();
    pop_ready = 1'b1;
    tick();
    tick();
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    instr      = 32'h0010_0113;
    pc         = 32'h10;
    tick();
    instr      = 32'h0020_0193;
    pc         = 32'h14;
    tick();
    push_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("[TB] FAIL wrap_refill_count got %0d exp 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      pop_ready = 1'b1;
      #1;
      checks++;
      if (pc_out !== exp_pc[i] || pop_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL wrap_order got pc %h valid %b exp pc %h valid 1",
                           pc_out, pop_valid, exp_pc[i]);
      end
      tick();
    end
    pop_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_empty got count %0d valid %b exp 0/0", count, pop_valid);
    end
  endtask

  task automatic test_simul();
    idle_inputs();
    push_valid = 1'b1;
    instr = 32'h0000_0A13; pc = 32'h20; tick();
    instr = 32'h0000_0B13; pc = 32'h24; tick();
    instr = 32'h0000_0C13; pc = 32'h28;
    pop_ready = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("[TB] FAIL simul_count got %0d exp 2", count);
    end
    checks++;
    if (pc_out !== 32'h24 || instr_out !== 32'h0000_0B13) begin
      errors++; $display("[TB] FAIL simul_head got %h/%h exp 00000b13/24", instr_out, pc_out);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    push_valid = 1'b1;
    instr = 32'h0000_0D13; pc = 32'h2C;
    tick();
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("[TB] FAIL flush_setup_count got %0d exp 3", count);
    end
    flush = 1'b1;
    instr = 32'h0000_0E13; pc = 32'h30;
    pop_ready = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || instr_out !== NOP_INSTR) begin
      errors++; $display("[TB] FAIL flush_state got count %0d valid %b instr %h exp 0/0/00000013",
                         count, pop_valid, instr_out);
    end
    tick();
    checks++;
    if (pop_valid !== 1'b0 || pc_out !== 32'h0) begin
      errors++; $display("[TB] FAIL flush_ghost got valid %b pc %h exp 0/0", pop_valid, pc_out);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] same_exp;
    logic [DW-1:0] next_exp;
    logic [CW-1:0] cnt_exp;
    same_exp = BYP ? 32'h0051_6093 : NOP_INSTR;
    next_exp = BYP ? NOP_INSTR : 32'h0051_6093;
    cnt_exp  = BYP ? CW'(0) : CW'(1);
    idle_inputs();
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    instr      = 32'h0051_6093;
    pc         = 32'h40;
    #1;
    checks++;
    if (instr_out !== same_exp || pop_valid !== BYP) begin
      errors++; $display("[TB] FAIL bypass_same got %h valid %b exp %h valid %b",
                         instr_out, pop_valid, same_exp, BYP);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== cnt_exp || instr_out !== next_exp) begin
      errors++; $display("[TB] FAIL bypass_next got count %0d instr %h exp %0d %h",
                         count, instr_out, cnt_exp, next_exp);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 59) != 0);
      push_valid = ($urandom_range(0, 3) != 0);
      pop_ready  = ($urandom_range(0, 2) == 0) || (i > 700 && $urandom_range(0, 1) == 1);
      flush      = ($urandom_range(0, 19) == 0);
      instr      = $urandom;
      pc         = $urandom;
      #1;
      checks++;
      if (pop_valid !== e_valid() || instr_out !== e_instr() || pc_out !== e_pc()) begin
        errors++; $display("[TB] FAIL rand_head cyc %0d got v%b %h/%h exp v%b %h/%h",
                           i, pop_valid, instr_out, pc_out, e_valid(), e_instr(), e_pc());
      end
      checks++;
      if (count !== CW'(q.size()) || push_ready !== (q.size() != DEPTH)) begin
        errors++; $display("[TB] FAIL rand_count cyc %0d got %0d rdy %b exp %0d rdy %b",
                           i, count, push_ready, q.size(), q.size() != DEPTH);
      end
      tick();
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_flush();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
